axi4_stream_sink_checker: RTL

- Slave-side terminator for an AXI4-Stream link; the receiving end of any master built on the team's stream interface.
- Drives tready with a programmable pseudo-random backpressure pattern.
- Checks each packet against the team's incrementing-byte test pattern and AXI4-Stream protocol rules.
- Keeps packet/byte statistics and sticky error flags; used in loopback benches and on-chip BIST.

---
 rtl/axi4_stream_chk_pkg.sv | 20 ++
 rtl/axi4_stream_if.sv | 30 +++
 rtl/axi4_stream_lfsr16.sv | 31 +++
 rtl/axi4_stream_sink_checker.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/axi4_stream_chk_pkg.sv
// Shared types and constants for the AXI4-Stream sink checker and its
// matching traffic generator.
package axi4_stream_chk_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } chk_state_t;

    localparam int ERR_DATA   = 0;
    localparam int ERR_KEEP   = 1;
    localparam int ERR_ID     = 2;
    localparam int ERR_LEN    = 3;
    localparam int ERR_STABLE = 4;
    localparam int ERR_W      = 5;

    // Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form).
    localparam logic [15:0] LFSR_POLY = 16'hB400;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle shared by the team's stream masters and slaves.
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 1
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [KEEP_WIDTH-1:0] tstrb;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        output tready
    );

endinterface

// File: rtl/axi4_stream_lfsr16.sv
// 16-bit Galois LFSR; exposes both the current state and the value it will
// take on the next advance so callers can register decisions on it.
module axi4_stream_lfsr16
    import axi4_stream_chk_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_advance,
    output logic [15:0] o_lfsr,
    output logic [15:0] o_lfsr_next
);

    logic [15:0] r_lfsr;
    logic [15:0] w_next;

    assign w_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_POLY : 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (i_advance) begin
            r_lfsr <= w_next;
        end
    end

    assign o_lfsr      = r_lfsr;
    assign o_lfsr_next = w_next;

endmodule

// File: rtl/axi4_stream_sink_checker.sv
// AXI4-Stream sink: pseudo-random tready, incrementing-byte pattern and
// protocol checking, packet/byte statistics with sticky error flags.
module axi4_stream_sink_checker
    import axi4_stream_chk_pkg::*;
#(
    parameter int          DATA_WIDTH    = 32,
    parameter int          ID_WIDTH      = 8,
    parameter int          DEST_WIDTH    = 4,
    parameter int          USER_WIDTH    = 1,
    parameter int          MAX_PKT_BYTES = 4096,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                aclk,
    input  logic                aresetn,
    axi4_stream_if.slave        pkt_i,
    input  logic                en_i,
    input  logic [3:0]          bp_ratio_i,
    input  logic                clear_i,
    output logic [31:0]         pkt_cnt_o,
    output logic [31:0]         byte_cnt_o,
    output logic [15:0]         last_len_o,
    output logic [ERR_W-1:0]    err_o
);

    localparam int KEEP_W  = DATA_WIDTH / 8;
    localparam int CNT_W   = $clog2(KEEP_W + 1);
    localparam int OFF_RAW = $clog2(MAX_PKT_BYTES + 1);
    localparam int OFF_W   = (OFF_RAW < 8) ? 8 : OFF_RAW;
    localparam int PAY_W   = DATA_WIDTH + 2 * KEEP_W + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
    localparam logic [31:0] MAX_BYTES = 32'(MAX_PKT_BYTES);

    chk_state_t            r_state;
    chk_state_t            w_state_next;
    logic                  r_tready;
    logic [OFF_W-1:0]      r_offset;
    logic [ID_WIDTH-1:0]   r_tid;
    logic [DEST_WIDTH-1:0] r_tdest;
    logic [31:0]           r_pkt_cnt;
    logic [31:0]           r_byte_cnt;
    logic [15:0]           r_last_len;
    logic [ERR_W-1:0]      r_err;
    logic                  r_stall;
    logic [PAY_W-1:0]      r_payload;

    logic [15:0]           w_lfsr_unused;
    logic [15:0]           w_lfsr_next;
    logic                  w_accept;
    logic                  w_latch_id;
    logic                  w_in_pkt;
    logic [CNT_W-1:0]      w_pop;
    logic [31:0]           w_sum;
    logic [31:0]           w_sum_sat;
    logic [KEEP_W-1:0]     w_keep_plus;
    logic                  w_keep_err;
    logic [KEEP_W-1:0]     w_lane_err;
    logic                  w_id_err;
    logic [PAY_W-1:0]      w_payload;
    logic                  w_stable_err;
    logic [ERR_W-1:0]      w_err_set;

    axi4_stream_lfsr16 #(
        .SEED        (LFSR_SEED)
    ) u_lfsr (
        .clk         (aclk),
        .rst_n       (aresetn),
        .i_advance   (1'b1),
        .o_lfsr      (w_lfsr_unused),
        .o_lfsr_next (w_lfsr_next)
    );

    assign w_accept = pkt_i.tvalid & r_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tready <= 1'b0;
        end else begin
            r_tready <= en_i & (w_lfsr_next[3:0] >= bp_ratio_i);
        end
    end

    // FSM: state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = pkt_i.tlast ? IDLE : IN_PKT;
        end
    end

    // FSM: outputs
    always_comb begin
        w_in_pkt   = (r_state == IN_PKT);
        w_latch_id = w_accept & (r_state == IDLE);
    end

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < KEEP_W; k++) begin
            w_pop = w_pop + CNT_W'(pkt_i.tkeep[k]);
        end
    end

    assign w_sum     = 32'(r_offset) + 32'(w_pop);
    assign w_sum_sat = (w_sum > MAX_BYTES) ? MAX_BYTES : w_sum;

    // Contiguous-from-lane-0 masks are exactly those with keep & (keep+1) == 0.
    assign w_keep_plus = pkt_i.tkeep + KEEP_W'(1);
    assign w_keep_err  = ((pkt_i.tkeep & w_keep_plus) != '0)
                       | (pkt_i.tkeep == '0)
                       | (!pkt_i.tlast && (pkt_i.tkeep != {KEEP_W{1'b1}}))
                       | (pkt_i.tstrb != pkt_i.tkeep);

    genvar gi;
    generate
        for (gi = 0; gi < KEEP_W; gi++) begin : g_lane
            assign w_lane_err[gi] = pkt_i.tkeep[gi]
                                  & (pkt_i.tdata[8*gi +: 8] != (r_offset[7:0] + 8'(gi)));
        end
    endgenerate

    assign w_id_err = w_in_pkt & ((pkt_i.tid != r_tid) | (pkt_i.tdest != r_tdest));

    assign w_payload = {pkt_i.tdata, pkt_i.tkeep, pkt_i.tstrb, pkt_i.tlast,
                        pkt_i.tid, pkt_i.tdest, pkt_i.tuser};
    assign w_stable_err = r_stall & (!pkt_i.tvalid | (w_payload != r_payload));

    always_comb begin
        w_err_set             = '0;
        w_err_set[ERR_DATA]   = w_accept & (|w_lane_err);
        w_err_set[ERR_KEEP]   = w_accept & w_keep_err;
        w_err_set[ERR_ID]     = w_accept & w_id_err;
        w_err_set[ERR_LEN]    = w_accept & (w_sum > MAX_BYTES);
        w_err_set[ERR_STABLE] = w_stable_err;
    end

    // Stall snapshot: compared against the bus one edge later.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_stall   <= 1'b0;
            r_payload <= '0;
        end else begin
            r_stall   <= pkt_i.tvalid & ~r_tready;
            r_payload <= w_payload;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_offset <= '0;
            r_tid    <= '0;
            r_tdest  <= '0;
        end else begin
            if (w_accept) begin
                r_offset <= pkt_i.tlast ? '0 : OFF_W'(w_sum_sat);
            end
            if (w_latch_id) begin
                r_tid   <= pkt_i.tid;
                r_tdest <= pkt_i.tdest;
            end
        end
    end

    // A clear coinciding with an accepted beat discards that beat's statistics.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pkt_cnt  <= '0;
            r_byte_cnt <= '0;
            r_last_len <= '0;
            r_err      <= '0;
        end else if (clear_i) begin
            r_pkt_cnt  <= '0;
            r_byte_cnt <= '0;
            r_last_len <= '0;
            r_err      <= '0;
        end else begin
            r_err <= r_err | w_err_set;
            if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 32'(w_pop);
                if (pkt_i.tlast) begin
                    r_pkt_cnt  <= r_pkt_cnt + 32'd1;
                    r_last_len <= 16'(w_sum);
                end
            end
        end
    end

    assign pkt_i.tready = r_tready;
    assign pkt_cnt_o    = r_pkt_cnt;
    assign byte_cnt_o   = r_byte_cnt;
    assign last_len_o   = r_last_len;
    assign err_o        = r_err;

endmodule
